padding_2d_unrolled: RTL and testbench

- Streaming 2-D zero/constant padder for the conv datapath; sits between the input feature-map stream and the sliding-window/im2col stage.
- Successor to the single-element, symmetric-pad padder. Adds:
  - independent top/bottom/left/right pad amounts;
  - UNROLL channels carried per beat;
  - a runtime pad constant;
  - explicit frame FSM with frame-last marker;
  - registered output with full throughput.

---
 rtl/padding_2d_unrolled.sv | 180 ++++++++++++++++++
 tb/tb_padding_2d_unrolled.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/padding_2d_unrolled.sv
// padding_2d_unrolled
// Streaming 2-D constant padder. It takes an input feature map in raster
// order, UNROLL channels per beat, and produces a padded feature map with
// independent top/bottom/left/right borders filled with a pad constant.
// The pad constant is latched once per frame.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   pad_value       pad constant, sampled when a frame starts (IDLE -> RUN)
//   data_in*        input stream (valid/ready); lane k = channel cg*UNROLL+k
//   data_out*       registered output stream (valid/ready), same lane packing
//   data_out_last   marks the final beat of each output frame
module padding_2d_unrolled #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 4,
  parameter int IMG_HEIGHT = 3,
  parameter int CHANNELS   = 4,
  parameter int UNROLL     = 2,
  parameter int PAD_TOP    = 1,
  parameter int PAD_BOTTOM = 1,
  parameter int PAD_LEFT   = 2,
  parameter int PAD_RIGHT  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        pad_value,
  input  logic [UNROLL*DATA_WIDTH-1:0] data_in,
  input  logic                         data_in_valid,
  output logic                         data_in_ready,
  output logic [UNROLL*DATA_WIDTH-1:0] data_out,
  output logic                         data_out_valid,
  input  logic                         data_out_ready,
  output logic                         data_out_last
);

  localparam int OUT_W = PAD_LEFT + IMG_WIDTH + PAD_RIGHT;
  localparam int OUT_H = PAD_TOP + IMG_HEIGHT + PAD_BOTTOM;
  localparam int G     = CHANNELS / UNROLL;
  localparam int CG_W  = (G > 1) ? $clog2(G) : 1;
  localparam int X_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int Y_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [CG_W-1:0] CG_LAST = CG_W'(G - 1);
  localparam logic [X_W-1:0]  X_LAST  = X_W'(OUT_W - 1);
  localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(OUT_H - 1);

  generate
    if (CHANNELS % UNROLL != 0) begin : g_bad_unroll
      $error("padding_2d_unrolled: CHANNELS must be a multiple of UNROLL");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                         state_q, state_d;
  logic [CG_W-1:0]                cg_q, cg_d;
  logic [X_W-1:0]                 x_q, x_d;
  logic [Y_W-1:0]                 y_q, y_d;
  logic [DATA_WIDTH-1:0]          pad_q, pad_d;
  logic [UNROLL*DATA_WIDTH-1:0]   data_q, data_d;
  logic                           valid_q, valid_d;
  logic                           last_q, last_d;

  logic load_ok;
  logic load;
  logic is_pad;
  logic at_end;

  // Current output position lies in the border rather than the image.
  assign is_pad = (int'(x_q) < PAD_LEFT) || (int'(x_q) >= PAD_LEFT + IMG_WIDTH) ||
                  (int'(y_q) < PAD_TOP)  || (int'(y_q) >= PAD_TOP + IMG_HEIGHT);

  assign at_end  = (cg_q == CG_LAST) && (x_q == X_LAST) && (y_q == Y_LAST);

  // The single output register may be refilled when empty or being drained
  // this cycle, which gives full throughput without a skid buffer.
  assign load_ok = !valid_q || data_out_ready;

  always_comb begin
    state_d       = state_q;
    cg_d          = cg_q;
    x_d           = x_q;
    y_d           = y_q;
    pad_d         = pad_q;
    data_d        = data_q;
    valid_d       = valid_q;
    last_d        = last_q;
    data_in_ready = 1'b0;
    load          = 1'b0;

    case (state_q)
      IDLE: begin
        // The last beat of the previous frame may still be waiting here.
        if (valid_q && data_out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
        // Frame start only latches the pad constant; the beat waits for RUN.
        if (data_in_valid) begin
          pad_d   = pad_value;
          state_d = RUN;
        end
      end

      RUN: begin
        if (is_pad) begin
          if (load_ok) begin
            load   = 1'b1;
            data_d = {UNROLL{pad_q}};
          end
        end else begin
          data_in_ready = load_ok;
          if (data_in_valid && load_ok) begin
            load   = 1'b1;
            data_d = data_in;
          end else if (load_ok) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end

        // Raster advance: channel group fastest, then column, then row.
        if (load) begin
          valid_d = 1'b1;
          last_d  = at_end;
          if (cg_q == CG_LAST) begin
            cg_d = '0;
            if (x_q == X_LAST) begin
              x_d = '0;
              if (y_q == Y_LAST) begin
                y_d = '0;
              end else begin
                y_d = y_q + Y_W'(1);
              end
            end else begin
              x_d = x_q + X_W'(1);
            end
          end else begin
            cg_d = cg_q + CG_W'(1);
          end
          if (at_end) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cg_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pad_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cg_q    <= cg_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pad_q   <= pad_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign data_out_last  = last_q;

endmodule

// File: tb/tb_padding_2d_unrolled.sv
// tb_padding_2d_unrolled
// Self-checking bench for padding_2d_unrolled. A padded instance with the
// default geometry is checked against an expected beat queue built by
// enumerating the padded frame in raster order; a second, unpadded instance
// with UNROLL=CHANNELS=4 is checked for one-cycle pass-through.
module tb_padding_2d_unrolled;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int IH = 3;
  localparam int CH = 4;
  localparam int UN = 2;
  localparam int PT = 1;
  localparam int PB = 1;
  localparam int PL = 2;
  localparam int PR = 0;
  localparam int OW = PL + IW + PR;
  localparam int OH = PT + IH + PB;
  localparam int G  = CH / UN;
  localparam int BW = UN * DW;

  localparam int UN_B     = 4;
  localparam int BW_B     = UN_B * DW;
  localparam int B_BEATS  = IW * IH;

  logic          clk;
  logic          rst;
  logic [DW-1:0] pad_value;
  logic [BW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [BW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;

  logic [DW-1:0]   b_pad_value;
  logic [BW_B-1:0] b_din;
  logic            b_din_valid;
  logic            b_din_ready;
  logic [BW_B-1:0] b_dout;
  logic            b_dout_valid;
  logic            b_dout_ready;
  logic            b_dout_last;

  padding_2d_unrolled #(
    .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .CHANNELS(CH), .UNROLL(UN),
    .PAD_TOP(PT), .PAD_BOTTOM(PB), .PAD_LEFT(PL), .PAD_RIGHT(PR)
  ) dut (
    .clk(clk), .rst(rst), .pad_value(pad_value),
    .data_in(din), .data_in_valid(din_valid), .data_in_ready(din_ready),
    .data_out(dout), .data_out_valid(dout_valid), .data_out_ready(dout_ready),
    .data_out_last(dout_last)
  );

  padding_2d_unrolled #(
    .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .CHANNELS(4), .UNROLL(UN_B),
    .PAD_TOP(0), .PAD_BOTTOM(0), .PAD_LEFT(0), .PAD_RIGHT(0)
  ) dut_b (
    .clk(clk), .rst(rst), .pad_value(b_pad_value),
    .data_in(b_din), .data_in_valid(b_din_valid), .data_in_ready(b_din_ready),
    .data_out(b_dout), .data_out_valid(b_dout_valid), .data_out_ready(b_dout_ready),
    .data_out_last(b_dout_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [BW-1:0]   src_q[$];
  logic [BW-1:0]   exp_data_q[$];
  bit              exp_last_q[$];
  logic [BW_B-1:0] b_src_q[$];

  bit rand_valid = 0;
  bit rand_ready = 0;
  int out_cnt = 0;
  int in_hs = 0;
  int last_cnt = 0;

  bit            prev_stall = 0;
  logic [BW-1:0] prev_data;
  logic          prev_last;

  int              b_hs = 0;
  bit              b_pend = 0;
  logic [BW_B-1:0] b_exp;
  bit              b_exp_last;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Builds one padded frame: input beats go to the source queue, and every
  // output beat (pad or image) plus its last flag goes to the expected queue.
  task automatic applyStimulus(input logic [DW-1:0] padv, input bit det);
    int k;
    bit is_pad;
    logic [BW-1:0] beat;
    k = 0;
    for (int y = 0; y < OH; y++) begin
      for (int x = 0; x < OW; x++) begin
        for (int cg = 0; cg < G; cg++) begin
          is_pad = (x < PL) || (x >= PL + IW) || (y < PT) || (y >= PT + IH);
          if (is_pad) begin
            beat = {UN{padv}};
          end else begin
            if (det) begin
              for (int j = 0; j < UN; j++) beat[j*DW +: DW] = DW'(k*UN + j + 1);
            end else begin
              beat = BW'($urandom);
            end
            src_q.push_back(beat);
            k++;
          end
          exp_data_q.push_back(beat);
          exp_last_q.push_back((y == OH-1) && (x == OW-1) && (cg == G-1));
        end
      end
    end
  endtask

  task automatic waitDrain(input string tag);
    int cyc;
    cyc = 0;
    while ((exp_data_q.size() > 0 || src_q.size() > 0) && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    checkOutput({tag, "_drained"}, 64'(exp_data_q.size()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic waitOutputs(input string tag, input int target);
    int cyc;
    cyc = 0;
    while (out_cnt < target && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    if (out_cnt < target) checkOutput({tag, "_timeout"}, 64'(out_cnt), 64'(target));
  endtask

  task automatic resetDut(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    src_q.delete();
    exp_data_q.delete();
    exp_last_q.delete();
    b_src_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_rst_valid"}, 64'(dout_valid), 64'd0);
    checkOutput({tag, "_rst_last"},  64'(dout_last),  64'd0);
    checkOutput({tag, "_rst_data"},  64'(dout),       64'd0);
    checkOutput({tag, "_rst_ready"}, 64'(din_ready),  64'd0);
    checkOutput({tag, "_rst_b_valid"}, 64'(b_dout_valid), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Input driver: refreshes both sources just after each rising edge.
  initial begin
    din_valid    = 1'b0;
    din          = '0;
    dout_ready   = 1'b1;
    b_din_valid  = 1'b0;
    b_din        = '0;
    b_dout_ready = 1'b1;
    b_pad_value  = 8'h3C;
    forever begin
      @(posedge clk);
      #1;
      if (rst || src_q.size() == 0) begin
        din_valid = 1'b0;
      end else begin
        din_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        din       = src_q[0];
      end
      dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst || b_src_q.size() == 0) begin
        b_din_valid = 1'b0;
      end else begin
        b_din_valid = 1'b1;
        b_din       = b_src_q[0];
      end
    end
  end

  // Monitor for the padded instance: handshakes seen at the falling edge
  // complete on the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", 64'(dout_valid), 64'd1);
        checkOutput("stall_data",  64'(dout),       64'(prev_data));
        checkOutput("stall_last",  64'(dout_last),  64'(prev_last));
      end
      if (din_valid && din_ready) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        in_hs++;
      end
      if (dout_valid && dout_ready) begin
        if (exp_data_q.size() == 0) begin
          checkOutput($sformatf("unexpected_beat[%0d]", out_cnt), 64'd1, 64'd0);
        end else begin
          checkOutput($sformatf("beat_data[%0d]", out_cnt), 64'(dout), 64'(exp_data_q.pop_front()));
          checkOutput($sformatf("beat_last[%0d]", out_cnt), 64'(dout_last), 64'(exp_last_q.pop_front()));
        end
        out_cnt++;
        if (dout_last) last_cnt++;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_data  = dout;
      prev_last  = dout_last;
    end
  end

  // Monitor for the unpadded instance: each accepted beat must appear on
  // the output exactly one cycle later.
  always @(negedge clk) begin
    if (rst) begin
      b_pend = 0;
    end else begin
      if (b_pend) begin
        checkOutput($sformatf("b_valid[%0d]", b_hs), 64'(b_dout_valid), 64'd1);
        checkOutput($sformatf("b_data[%0d]", b_hs),  64'(b_dout), 64'(b_exp));
        checkOutput($sformatf("b_last[%0d]", b_hs),  64'(b_dout_last), 64'(b_exp_last));
        b_pend = 0;
      end
      if (b_din_valid && b_din_ready) begin
        b_hs++;
        b_exp      = b_din;
        b_exp_last = (b_hs == B_BEATS);
        b_pend     = 1;
        if (b_src_q.size() > 0) void'(b_src_q.pop_front());
      end
    end
  end

  initial begin
    int base;
    int cyc;
    rst       = 1'b1;
    pad_value = 8'hAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("init_valid", 64'(dout_valid), 64'd0);
    checkOutput("init_last",  64'(dout_last),  64'd0);
    checkOutput("init_data",  64'(dout),       64'd0);
    checkOutput("init_ready", 64'(din_ready),  64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Deterministic frame, output always ready.
    $display("[TB] frame with counting data, ready high");
    in_hs = 0; last_cnt = 0; out_cnt = 0;
    applyStimulus(8'hAA, 1);
    waitDrain("t1");
    checkOutput("t1_in_hs", 64'(in_hs), 64'd24);
    checkOutput("t1_last_cnt", 64'(last_cnt), 64'd1);
    checkOutput("t1_out_cnt", 64'(out_cnt), 64'd60);

    // Same frame under random backpressure, then random valid too.
    $display("[TB] random backpressure");
    rand_ready = 1; in_hs = 0;
    applyStimulus(8'hAA, 1);
    waitDrain("t2");
    checkOutput("t2_in_hs", 64'(in_hs), 64'd24);
    rand_valid = 1; in_hs = 0;
    applyStimulus(8'hAA, 0);
    waitDrain("t2r");
    checkOutput("t2r_in_hs", 64'(in_hs), 64'd24);
    rand_valid = 0; rand_ready = 0;

    // Unpadded instance: 12 beats straight through.
    $display("[TB] unpadded pass-through");
    b_hs = 0;
    for (int i = 0; i < B_BEATS; i++) b_src_q.push_back(BW_B'($urandom));
    cyc = 0;
    while (b_src_q.size() > 0 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    checkOutput("t3_hs", 64'(b_hs), 64'(B_BEATS));

    // Pad constant change mid-frame must not leak into the running frame.
    $display("[TB] pad constant change mid-frame");
    rand_ready = 1;
    base = out_cnt;
    applyStimulus(8'hAA, 0);
    waitOutputs("t4", base + 10);
    pad_value = 8'h55;
    waitDrain("t4a");
    applyStimulus(8'h55, 0);
    waitDrain("t4b");
    rand_ready = 0;

    // Reset partway through a frame, then a fresh complete frame.
    $display("[TB] reset mid-frame");
    base = out_cnt;
    applyStimulus(8'h55, 0);
    waitOutputs("t5", base + 20);
    resetDut("t5");
    in_hs = 0; last_cnt = 0;
    applyStimulus(8'h55, 0);
    waitDrain("t5");
    checkOutput("t5_in_hs", 64'(in_hs), 64'd24);
    checkOutput("t5_last_cnt", 64'(last_cnt), 64'd1);

    // Two frames back to back with input valid held high.
    $display("[TB] back-to-back frames");
    in_hs = 0; last_cnt = 0; base = out_cnt;
    applyStimulus(8'h55, 0);
    applyStimulus(8'h55, 0);
    waitDrain("t6");
    checkOutput("t6_in_hs", 64'(in_hs), 64'd48);
    checkOutput("t6_last_cnt", 64'(last_cnt), 64'd2);
    checkOutput("t6_out_cnt", 64'(out_cnt - base), 64'd120);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
